// File: rtl/ccip_wr_responder.sv
// CCI-P write-channel responder: assembles multi-beat write packets and fences, queues them,
// and returns one response header per packet after a fixed minimum latency, in order.
module ccip_wr_responder #(
  parameter int unsigned FIFO_DEPTH_BASE2  = 4,
  parameter int unsigned RSP_LATENCY       = 8,
  parameter int unsigned ALMFULL_THRESHOLD = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_valid,
  input  logic [79:0]               tx_hdr,
  output logic                      tx_almfull,
  output logic                      rx_valid,
  output logic [27:0]               rx_hdr,
  output logic [FIFO_DEPTH_BASE2:0] outstanding,
  output logic                      err,
  output logic [2:0]                err_code
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BASE2;
  localparam int unsigned CntW  = FIFO_DEPTH_BASE2 + 1;
  localparam logic [7:0]  Lat   = 8'(RSP_LATENCY);

  typedef enum logic {StIdle, StMidpkt} state_e;

  state_e state_q, state_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d, pkt_len_q, pkt_len_d, pkt_vc_q, pkt_vc_d;
  logic [15:0] pkt_mdata_q, pkt_mdata_d;
  logic [7:0]  cycle_cnt_q;
  logic [FIFO_DEPTH_BASE2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic        almfull_q, rx_valid_q, err_q;
  logic [27:0] rx_hdr_q;
  logic [2:0]  err_code_q;

  logic        q_kind  [Depth];
  logic [1:0]  q_vc    [Depth];
  logic [1:0]  q_len   [Depth];
  logic [15:0] q_mdata [Depth];
  logic [7:0]  q_stamp [Depth];

  logic [1:0]  b_vc, b_len;
  logic        b_sop, legal, is_fence;
  logic [3:0]  b_type;
  logic [15:0] b_mdata;
  logic        enq, enq_kind, enq_ok, deq, full, beat_err, err_set;
  logic [1:0]  enq_vc, enq_len;
  logic [15:0] enq_mdata;
  logic [2:0]  beat_cause, err_cause;
  logic [7:0]  head_age;
  logic [1:0]  head_vc_used;
  logic [27:0] rsp_hdr;
  logic        unused_hdr_bits;

  assign b_vc     = tx_hdr[73:72];
  assign b_sop    = tx_hdr[71];
  assign b_len    = tx_hdr[69:68];
  assign b_type   = tx_hdr[67:64];
  assign b_mdata  = tx_hdr[15:0];
  assign legal    = (b_type == 4'd3) || (b_type == 4'd4) || (b_type == 4'd6);
  assign is_fence = (b_type == 4'd6);
  assign unused_hdr_bits = ^{tx_hdr[79:74], tx_hdr[70], tx_hdr[63:16]};

  // Packet assembly; a sop beat arriving mid-packet falls through to the idle handling.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_len_d   = pkt_len_q;
    pkt_vc_d    = pkt_vc_q;
    pkt_mdata_d = pkt_mdata_q;
    enq         = 1'b0;
    enq_kind    = 1'b0;
    enq_vc      = 2'd0;
    enq_len     = 2'd0;
    enq_mdata   = 16'd0;
    beat_err    = 1'b0;
    beat_cause  = 3'd0;
    if (tx_valid) begin
      if (!legal) begin
        beat_err   = 1'b1;
        beat_cause = 3'd3;
      end else if (is_fence) begin
        if (state_q == StMidpkt) begin
          beat_err   = 1'b1;
          beat_cause = 3'd5;
        end else begin
          enq       = 1'b1;
          enq_kind  = 1'b1;
          enq_vc    = b_vc;
          enq_mdata = b_mdata;
        end
      end else if (state_q == StMidpkt && !b_sop) begin
        if (beat_cnt_q == pkt_len_q) begin
          enq       = 1'b1;
          enq_vc    = pkt_vc_q;
          enq_len   = pkt_len_q;
          enq_mdata = pkt_mdata_q;
          state_d   = StIdle;
        end else begin
          beat_cnt_d = beat_cnt_q + 2'd1;
        end
      end else begin
        if (state_q == StMidpkt) begin
          beat_err   = 1'b1;
          beat_cause = 3'd2;
        end
        if (!b_sop) begin
          beat_err   = 1'b1;
          beat_cause = 3'd1;
        end else if (b_len == 2'd0) begin
          enq       = 1'b1;
          enq_vc    = b_vc;
          enq_mdata = b_mdata;
          state_d   = StIdle;
        end else begin
          pkt_len_d   = b_len;
          pkt_vc_d    = b_vc;
          pkt_mdata_d = b_mdata;
          beat_cnt_d  = 2'd1;
          state_d     = StMidpkt;
        end
      end
    end
  end

  assign head_age = cycle_cnt_q - q_stamp[rd_ptr_q];
  assign deq      = (count_q != '0) && (head_age >= Lat);
  assign full     = (count_q == CntW'(Depth));
  assign enq_ok   = enq && (!full || deq);
  assign err_set  = beat_err || (enq && !enq_ok);
  assign err_cause = beat_err ? beat_cause : 3'd4;

  assign head_vc_used = (q_vc[rd_ptr_q] == 2'd0) ? 2'd1 : q_vc[rd_ptr_q];

  always_comb begin
    if (q_kind[rd_ptr_q]) begin
      rsp_hdr = {head_vc_used, 4'b0000, 2'd0, 4'd4, q_mdata[rd_ptr_q]};
    end else begin
      rsp_hdr = {head_vc_used, 1'b0, 1'b0, (q_len[rd_ptr_q] != 2'd0), 1'b0,
                 q_len[rd_ptr_q], 4'd2, q_mdata[rd_ptr_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_cnt_q  <= 2'd0;
      pkt_len_q   <= 2'd0;
      pkt_vc_q    <= 2'd0;
      pkt_mdata_q <= 16'd0;
      cycle_cnt_q <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      almfull_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_hdr_q    <= 28'd0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_len_q   <= pkt_len_d;
      pkt_vc_q    <= pkt_vc_d;
      pkt_mdata_q <= pkt_mdata_d;
      cycle_cnt_q <= cycle_cnt_q + 8'd1;
      if (enq_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_q + CntW'(enq_ok) - CntW'(deq);
      almfull_q   <= (count_q >= CntW'(ALMFULL_THRESHOLD));
      rx_valid_q  <= deq;
      rx_hdr_q    <= deq ? rsp_hdr : 28'd0;
      if (err_set && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_cause;
      end
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && enq_ok) begin
      q_kind[wr_ptr_q]  <= enq_kind;
      q_vc[wr_ptr_q]    <= enq_vc;
      q_len[wr_ptr_q]   <= enq_len;
      q_mdata[wr_ptr_q] <= enq_mdata;
      q_stamp[wr_ptr_q] <= cycle_cnt_q;
    end
  end

  assign tx_almfull  = almfull_q;
  assign rx_valid    = rx_valid_q;
  assign rx_hdr      = rx_hdr_q;
  assign outstanding = count_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ccip_wr_responder.sv
// Bench for ccip_wr_responder: directed beats feed an expected-response queue that a separate
// monitor drains and compares (header and arrival cycle) whenever rx_valid is seen.
module tb_ccip_wr_responder;

  localparam int unsigned Lat = 255;

  logic        clk = 1'b0;
  logic        rst, tx_valid, tx_almfull, rx_valid, err;
  logic [79:0] tx_hdr;
  logic [27:0] rx_hdr;
  logic [4:0]  outstanding;
  logic [2:0]  err_code;

  int unsigned edge_cnt = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [27:0] exp_hdr_q[$];
  int unsigned exp_cyc_q[$];

  ccip_wr_responder #(
    .FIFO_DEPTH_BASE2 (4),
    .RSP_LATENCY      (Lat),
    .ALMFULL_THRESHOLD(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_hdr     (tx_hdr),
    .tx_almfull (tx_almfull),
    .rx_valid   (rx_valid),
    .rx_hdr     (rx_hdr),
    .outstanding(outstanding),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [27:0] mk(input logic [1:0] vcu, input logic fmt, input logic [1:0] cl,
                                     input logic [3:0] rt, input logic [15:0] md);
    return {vcu, 1'b0, 1'b0, fmt, 1'b0, cl, rt, md};
  endfunction

  task automatic send(input logic [1:0] vc, input logic sop, input logic [1:0] len,
                      input logic [3:0] rt, input logic [15:0] md);
    tx_hdr = '0;
    tx_hdr[73:72] = vc;
    tx_hdr[71]    = sop;
    tx_hdr[69:68] = len;
    tx_hdr[67:64] = rt;
    tx_hdr[15:0]  = md;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Called right after the enqueuing beat's edge; the response is due Lat cycles later.
  task automatic expect_rsp(input logic [27:0] h);
    exp_hdr_q.push_back(h);
    exp_cyc_q.push_back(edge_cnt + Lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < Lat + 40 && exp_hdr_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_hdr_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (exp_hdr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got hdr %h at cycle %0d, want none", rx_hdr, edge_cnt);
      end else begin
        check("rsp_hdr", rx_hdr, exp_hdr_q.pop_front());
        check("rsp_cycle", edge_cnt, exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_hdr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_hdr", rx_hdr, 0);
    check("rst_almfull", tx_almfull, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);

    // Single line, VA maps to VL0
    send(2'd0, 1'b1, 2'd0, 4'd3, 16'h1234);
    expect_rsp(mk(2'd1, 1'b0, 2'd0, 4'd2, 16'h1234));
    check("single_outstanding", outstanding, 1);

    // 4-CL packet on VH0; non-sop beat mdata must not leak into the response
    send(2'd2, 1'b1, 2'd3, 4'd4, 16'h00AA);
    send(2'd2, 1'b0, 2'd3, 4'd4, 16'hBEEF);
    send(2'd2, 1'b0, 2'd3, 4'd4, 16'hBEEF);
    send(2'd2, 1'b0, 2'd3, 4'd4, 16'hBEEF);
    expect_rsp(mk(2'd2, 1'b1, 2'd3, 4'd2, 16'h00AA));

    // Writes then fence, back to back; fence sop/len ignored
    for (int k = 1; k <= 3; k++) begin
      send(2'd1, 1'b1, 2'd0, 4'd3, 16'(k));
      expect_rsp(mk(2'd1, 1'b0, 2'd0, 4'd2, 16'(k)));
    end
    send(2'd3, 1'b0, 2'd2, 4'd6, 16'h00F0);
    expect_rsp(mk(2'd3, 1'b0, 2'd0, 4'd4, 16'h00F0));
    wait_drain();
    check("no_err_clean", err, 0);

    // Fill, almfull timing, overflow
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      send(2'd0, 1'b1, 2'd0, 4'd3, 16'(k));
      expect_rsp(mk(2'd1, 1'b0, 2'd0, 4'd2, 16'(k)));
      if (k == 12) begin
        check("fill12_outstanding", outstanding, 12);
        check("fill12_almfull", tx_almfull, 0);
      end
      if (k == 13) check("fill13_almfull", tx_almfull, 1);
    end
    send(2'd0, 1'b1, 2'd0, 4'd3, 16'h0011);
    check("ovf_err", err, 1);
    check("ovf_err_code", err_code, 4);
    check("ovf_outstanding", outstanding, 16);
    wait_drain();

    // sop=0 while idle
    do_reset();
    send(2'd0, 1'b0, 2'd0, 4'd3, 16'h0099);
    check("nosop_err_code", err_code, 1);
    check("nosop_outstanding", outstanding, 0);

    // sop mid-packet abandons the partial; first error is kept
    do_reset();
    send(2'd2, 1'b1, 2'd2, 4'd3, 16'h0BAD);
    send(2'd0, 1'b1, 2'd0, 4'd3, 16'h0055);
    expect_rsp(mk(2'd1, 1'b0, 2'd0, 4'd2, 16'h0055));
    check("midsop_err_code", err_code, 2);
    send(2'd0, 1'b1, 2'd0, 4'd5, 16'h0066);
    check("first_err_kept", err_code, 2);
    check("midsop_outstanding", outstanding, 1);
    wait_drain();

    // Illegal reqtype
    do_reset();
    send(2'd0, 1'b1, 2'd0, 4'd7, 16'h0033);
    check("badtype_err_code", err_code, 3);
    check("badtype_outstanding", outstanding, 0);

    // Fence mid-packet is dropped; packet still completes
    do_reset();
    send(2'd2, 1'b1, 2'd1, 4'd3, 16'h0077);
    send(2'd0, 1'b0, 2'd0, 4'd6, 16'h0088);
    check("midfence_err_code", err_code, 5);
    send(2'd2, 1'b0, 2'd1, 4'd3, 16'h0000);
    expect_rsp(mk(2'd2, 1'b1, 2'd1, 4'd2, 16'h0077));
    wait_drain();

    // Reset with pending entries and a partial packet: nothing may come out
    do_reset();
    for (int k = 0; k < 5; k++) send(2'd0, 1'b1, 2'd0, 4'd3, 16'(16'h0100 + k));
    send(2'd1, 1'b1, 2'd3, 4'd3, 16'h0200);
    check("pre_rst_outstanding", outstanding, 5);
    do_reset();
    check("post_rst_outstanding", outstanding, 0);
    check("post_rst_err", err, 0);
    repeat (300) @(negedge clk);
    check("post_rst_outstanding_late", outstanding, 0);
    check("final_pending", exp_hdr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
